// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier with start/done handshake.
// One add/subtract cycle (EVAL) and one arithmetic-shift cycle (SHIFT) per
// bit of the (WIDTH+1)-bit extended multiplier; signed/unsigned operands
// are handled purely by how the operands are extended at load time.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; operands are captured when start is seen
//   EVAL  | Booth decode of {Qx[0], q_m1}: add, subtract or keep A
//   SHIFT | arithmetic right shift of {A, Qx, q_m1}; count one iteration
//   DONE  | product register holds the new result; done pulses for one cycle
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int AW = WIDTH + 2;
    localparam int QW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] N_ITER = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] a_r;
    logic [AW-1:0] mx_r;
    logic [QW-1:0] qx_r;
    logic          q_m1_r;
    logic [CW-1:0] cnt_r;

    logic [AW-1:0] mx_ext;
    logic [QW-1:0] qx_ext;
    logic [AW-1:0] a_sh;
    logic [QW-1:0] qx_sh;
    logic          last_iter;

    // Operand extension: sign- or zero-extend depending on mode
    always_comb begin
        mx_ext = {2'b00, multiplicand};
        qx_ext = {1'b0, multiplier};
        if (is_signed) begin
            mx_ext = {{2{multiplicand[WIDTH-1]}}, multiplicand};
            qx_ext = {multiplier[WIDTH-1], multiplier};
        end
    end

    // Shifted view of {A, Qx, q_m1}; A's MSB is replicated
    always_comb begin
        a_sh      = {a_r[AW-1], a_r[AW-1:1]};
        qx_sh     = {a_r[0], qx_r[QW-1:1]};
        last_iter = (cnt_r == CW'(1));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status decodes (outputs depend on state only)
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                busy      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                busy      = 1'b1;
                state_nxt = last_iter ? DONE : EVAL;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: load, Booth add/subtract, shift/count, result capture.
    // The product is captured on the final shift so it is already valid
    // in the cycle where done is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r     <= '0;
            mx_r    <= '0;
            qx_r    <= '0;
            q_m1_r  <= 1'b0;
            cnt_r   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= '0;
                        mx_r   <= mx_ext;
                        qx_r   <= qx_ext;
                        q_m1_r <= 1'b0;
                        cnt_r  <= N_ITER;
                    end
                end
                EVAL: begin
                    case ({qx_r[0], q_m1_r})
                        2'b01:   a_r <= a_r + mx_r;
                        2'b10:   a_r <= a_r - mx_r;
                        default: a_r <= a_r;
                    endcase
                end
                SHIFT: begin
                    a_r    <= a_sh;
                    qx_r   <= qx_sh;
                    q_m1_r <= qx_r[0];
                    cnt_r  <= cnt_r - CW'(1);
                    if (last_iter) begin
                        product <= {a_sh[WIDTH-2:0], qx_sh};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
